// File: rtl/spike_demux_if.sv
// Handshake/bus bundle between the multiplexed column driver and spike_demux.
interface spike_demux_if #(
  parameter int unsigned Q = 2
);
  logic         grst;
  logic [Q-1:0] col_spikes;
  logic [Q-1:0] output_spikes1;
  logic [Q-1:0] output_spikes2;
  logic         phase;
  logic         replay_valid;

  // Driver side: issues gamma starts and column spikes, observes replay.
  modport master (
    output grst, col_spikes,
    input  output_spikes1, output_spikes2, phase, replay_valid
  );

  // Demux side.
  modport slave (
    input  grst, col_spikes,
    output output_spikes1, output_spikes2, phase, replay_valid
  );
endinterface

// File: rtl/spike_demux.sv
// Time-stamps column spikes per network over two gamma sub-cycles and replays
// both networks concurrently during the following phase-0 sub-cycle.
module spike_demux #(
  parameter int unsigned Q  = 2,
  parameter int unsigned TW = 3
) (
  input  logic         clk,
  input  logic         rst,
  spike_demux_if.slave bus
);

  localparam logic [TW-1:0] T_MAX = '1;

  typedef enum logic {
    PH_NET1 = 1'b0,
    PH_NET2 = 1'b1
  } phase_e;

  phase_e state_q, state_d;

  logic [TW-1:0]              tcnt;
  logic [TW-1:0]              cur_t;
  logic                       ph;
  logic                       enter0;

  logic [1:0][Q-1:0]          cap_v;
  logic [1:0][Q-1:0][TW-1:0]  cap_t;
  logic [1:0][Q-1:0]          rep_v;
  logic [1:0][Q-1:0][TW-1:0]  rep_t;
  logic [Q-1:0]               out1_q;
  logic [Q-1:0]               out2_q;
  logic                       rv_q;

  assign ph     = (state_q == PH_NET2);
  assign cur_t  = bus.grst ? '0 : tcnt;
  assign enter0 = bus.grst && (state_q == PH_NET2);

  // Phase state register; reset parks in network 2 so the first grst enters phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PH_NET2;
    else     state_q <= state_d;
  end

  // Phase toggles on every gamma start.
  always_comb begin
    state_d = state_q;
    if (bus.grst) state_d = (state_q == PH_NET1) ? PH_NET2 : PH_NET1;
  end

  // Shared time base: restarts at 1 after grst and saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tcnt <= '0;
    else if (bus.grst)       tcnt <= TW'(1);
    else if (tcnt != T_MAX)  tcnt <= tcnt + TW'(1);
  end

  // Capture first spike per neuron into the active bank; grst cycles are blanked
  // because the column may still be holding its previous level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_v <= '0;
      cap_t <= '0;
    end else if (bus.grst) begin
      if (enter0) begin
        cap_v[0] <= '0;
        cap_t[0] <= '0;
      end else begin
        cap_v[1] <= '0;
        cap_t[1] <= '0;
      end
    end else begin
      for (int q = 0; q < Q; q++) begin
        if (bus.col_spikes[q] && !cap_v[ph][q]) begin
          cap_v[ph][q] <= 1'b1;
          cap_t[ph][q] <= cur_t;
        end
      end
    end
  end

  // Transfer both banks on phase-0 entry (clearing outputs), then replay by stamp match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_v  <= '0;
      rep_t  <= '0;
      out1_q <= '0;
      out2_q <= '0;
      rv_q   <= 1'b0;
    end else if (enter0) begin
      rep_v  <= cap_v;
      rep_t  <= cap_t;
      out1_q <= '0;
      out2_q <= '0;
      rv_q   <= 1'b1;
    end else if (!bus.grst && !ph) begin
      for (int q = 0; q < Q; q++) begin
        if (rep_v[0][q] && (cur_t == rep_t[0][q])) out1_q[q] <= 1'b1;
        if (rep_v[1][q] && (cur_t == rep_t[1][q])) out2_q[q] <= 1'b1;
      end
    end
  end

  assign bus.output_spikes1 = out1_q;
  assign bus.output_spikes2 = out2_q;
  assign bus.phase          = ph;
  assign bus.replay_valid   = rv_q;

endmodule
